// File: rtl/serial_sub_pkg.sv
// ----------------------------------------------------------------------------
// serial_sub_pkg
// Shared types for the bit-serial subtractor: the control FSM state type and
// its encoding constants.
// ----------------------------------------------------------------------------
package serial_sub_pkg;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_SHIFT_ENC = 2'd1;
    localparam logic [1:0] ST_DONE_ENC  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE_ENC,
        SHIFT = ST_SHIFT_ENC,
        DONE  = ST_DONE_ENC
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// ----------------------------------------------------------------------------
// full_subtractor
// Single-bit combinational full subtractor computing x - y - bin.
// Ports:
//   x    : minuend bit
//   y    : subtrahend bit
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
// ----------------------------------------------------------------------------
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic w_xy;

    assign w_xy = x ^ y;
    assign d    = w_xy ^ bin;
    // Borrow when x=0,y=1, or when x==y and a borrow is pending.
    assign bout = (~x & y) | (~w_xy & bin);

endmodule

// File: rtl/serial_subtractor.sv
// ----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial WIDTH-bit subtractor: diff = a - b, processed LSB first, one bit
// per clock through one full_subtractor cell and a registered borrow.
// A start/done handshake controls it; start is only accepted in IDLE or DONE.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the signed-overflow port ovf.
// Ports:
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset
//   start  : operation request (ignored while busy)
//   a, b   : operands, captured when start is accepted
//   busy   : high while bits are being processed
//   done   : one-cycle pulse, result outputs valid
//   diff   : (a - b) mod 2^WIDTH, held until the next result
//   borrow : final borrow out (a < b unsigned)
//   ovf    : signed overflow (SERIAL_SUB_OVF_EN only)
// ----------------------------------------------------------------------------
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             borrow,
    output logic             ovf
`else
    output logic             borrow
`endif
);

    localparam int CW = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_next;
    logic             w_load;
    logic             w_last;

    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    // Holds the first WIDTH-1 result bits; the final bit is merged in
    // directly when the output register is loaded.
    logic [WIDTH-2:0] r_diff_sr;
    logic [WIDTH-1:0] w_shift;
    logic             r_bin;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;

    logic             w_d;
    logic             w_bout;

    full_subtractor u_cell (
        .x    (r_a_sr[0]),
        .y    (r_b_sr[0]),
        .bin  (r_bin),
        .d    (w_d),
        .bout (w_bout)
    );

    assign w_last  = (r_cnt == CW'(WIDTH - 1));
    assign w_shift = {w_d, r_diff_sr};

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = SHIFT;
                end
            end
            SHIFT: begin
                if (w_last) w_next = DONE;
            end
            DONE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = SHIFT;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sr    <= '0;
            r_b_sr    <= '0;
            r_diff_sr <= '0;
            r_bin     <= 1'b0;
            r_cnt     <= '0;
            r_diff    <= '0;
            r_borrow  <= 1'b0;
        end else if (w_load) begin
            r_a_sr <= a;
            r_b_sr <= b;
            r_bin  <= 1'b0;
            r_cnt  <= '0;
        end else if (r_state == SHIFT) begin
            r_a_sr    <= r_a_sr >> 1;
            r_b_sr    <= r_b_sr >> 1;
            r_diff_sr <= w_shift[WIDTH-1:1];
            r_bin     <= w_bout;
            // Counter stops at WIDTH-1; only a reload clears it.
            if (!w_last) r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_diff   <= w_shift;
                r_borrow <= w_bout;
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_load) begin
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
        end else if (r_state == SHIFT && w_last) begin
            // Final bit processed here is the result MSB.
            r_ovf <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
        end
    end

    assign ovf = r_ovf;
`endif

    assign busy   = (r_state == SHIFT);
    assign done   = (r_state == DONE);
    assign diff   = r_diff;
    assign borrow = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] last_diff;
    logic         last_borrow;
    logic         last_ovf;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
`ifdef SERIAL_SUB_OVF_EN
        .borrow (borrow),
        .ovf    (ovf)
`else
        .borrow (borrow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain arithmetic on the operands.
    function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y);
        return x - y;
    endfunction

    function automatic logic ref_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
        return (x < y);
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
        int sd;
        sd = int'($signed(x)) - int'($signed(y));
        return (sd > (2 ** (W - 1)) - 1) || (sd < -(2 ** (W - 1)));
    endfunction

    task automatic check_result(input string tag);
        check_val({tag, "_diff"}, 32'(diff), 32'(last_diff));
        check_val({tag, "_borrow"}, 32'(borrow), 32'(last_borrow));
`ifdef SERIAL_SUB_OVF_EN
        check_val({tag, "_ovf"}, 32'(ovf), 32'(last_ovf));
`endif
    endtask

    // Caller sits 1 time unit after an edge with the block ready.
    // pulse_at >= 0 raises start again during SHIFT at that sample index.
    task automatic do_op(input string tag, input logic [W-1:0] ta,
                         input logic [W-1:0] tb_v, input int pulse_at);
        int busy_cnt;
        int done_cnt;
        busy_cnt = 0;
        done_cnt = 0;
        start = 1'b1;
        a     = ta;
        b     = tb_v;
        step();
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        for (int i = 0; i <= W; i++) begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            check_val({tag, "_busy"}, 32'(busy), 32'(i < W));
            check_val({tag, "_done"}, 32'(done), 32'(i == W));
            if (i == W) begin
                last_diff   = ref_diff(ta, tb_v);
                last_borrow = ref_borrow(ta, tb_v);
                last_ovf    = ref_ovf(ta, tb_v);
                check_result(tag);
            end else begin
                start = (i == pulse_at);
                if (i == pulse_at) begin
                    a = 8'hFF;
                    b = 8'h00;
                end
                step();
                start = 1'b0;
            end
        end
        check_val({tag, "_busycount"}, 32'(busy_cnt), 32'(W));
        check_val({tag, "_donecount"}, 32'(done_cnt), 32'd1);
        step();
        check_val({tag, "_idle_done"}, 32'(done), 32'd0);
        check_val({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check_result({tag, "_hold"});
    endtask

    initial begin
        int saw_done;
        logic [W-1:0] ra, rb;
        int per;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        last_diff   = '0;
        last_borrow = 1'b0;
        last_ovf    = 1'b0;
        step();
        step();
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_result("rst");
        rst = 1'b0;
        step();
        check_val("post_rst_done", 32'(done), 32'd0);

        do_op("op_05_03", 8'h05, 8'h03, -1);
        do_op("op_03_05", 8'h03, 8'h05, -1);
        do_op("op_00_00", 8'h00, 8'h00, -1);
        do_op("op_ignore", 8'h20, 8'h01, 2);

        // Back-to-back with start held high.
        per   = W + 1;
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'h01;
        step();
        for (int i = 0; i < 3 * per; i++) begin
            check_val("b2b_done", 32'(done), 32'((i % per) == W));
            check_val("b2b_busy", 32'(busy), 32'((i % per) != W));
            if ((i % per) == W) begin
                check_val("b2b_diff", 32'(diff), 32'h0FE);
                check_val("b2b_borrow", 32'(borrow), 32'd0);
            end
            if (i == 3 * per - 1) start = 1'b0;
            step();
        end
        check_val("b2b_end_done", 32'(done), 32'd0);
        check_val("b2b_end_busy", 32'(busy), 32'd0);
        last_diff   = 8'hFE;
        last_borrow = 1'b0;
        last_ovf    = ref_ovf(8'hFF, 8'h01);

        // Reset on cycle 4 of SHIFT aborts the operation.
        start = 1'b1;
        a     = 8'h5A;
        b     = 8'h33;
        step();
        start = 1'b0;
        step();
        step();
        step();
        check_val("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_done", 32'(done), 32'd0);
        last_diff   = '0;
        last_borrow = 1'b0;
        last_ovf    = 1'b0;
        check_result("abort");
        saw_done = 0;
        for (int i = 0; i < W + 3; i++) begin
            if (done) saw_done++;
            step();
        end
        check_val("abort_no_done", 32'(saw_done), 32'd0);
        do_op("after_abort", 8'hC3, 8'h3C, -1);

`ifdef SERIAL_SUB_OVF_EN
        do_op("ovf_80_01", 8'h80, 8'h01, -1);
        check_val("ovf_80_01_val", 32'(ovf), 32'd1);
        do_op("ovf_7F_01", 8'h7F, 8'h01, -1);
        check_val("ovf_7F_01_val", 32'(ovf), 32'd0);
`endif

        // Randomized operations with random idle gaps.
        for (int n = 0; n < 24; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            do_op("rand", ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 2)) : -1);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                a = W'($urandom);
                b = W'($urandom);
                step();
                check_result("rand_gap");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor computing a − b LSB-first, one bit per clock, through a single full-subtractor cell and a registered borrow. It is the subtracting counterpart to the team's half-adder arithmetic cells. It is used where area matters more than latency. A start/done handshake sits between it and the controlling logic.

## Interface
- WIDTH, 8, operand and result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when block is ready (IDLE or DONE)
- a  input  WIDTH  minuend, sampled with accepted start
- b  input  WIDTH  subtrahend, sampled with accepted start
- busy  output  1  high while in SHIFT
- done  output  1  single-cycle pulse, result valid
- diff  output  WIDTH  a − b modulo 2^WIDTH
- borrow  output  1  final borrow-out (1 when a < b unsigned)
- ovf  output  1  signed overflow (only with SERIAL_SUB_OVF_EN)

## Operation
- One clock, clk; reset is synchronous and active-high on rst. Reset wins over every other input.
- Reset values: state=IDLE, busy=0, done=0, diff=0, borrow=0, ovf=0, bit counter=0.
- States:
  - IDLE: ready. Accepted start → load a, b into shift registers, clear borrow register and counter → SHIFT.
  - SHIFT: each cycle feeds a_sr[0], b_sr[0] and the borrow register into the cell.
    - The difference bit shifts into diff_sr MSB-end. The borrow register takes bout. a_sr and b_sr shift right. The counter increments.
    - When the counter reaches WIDTH−1, the last bit is processed → DONE.
  - DONE: done=1 for exactly this cycle; diff/borrow present final values. Accepted start → load as in IDLE → SHIFT (back-to-back). Otherwise → IDLE.
- start in SHIFT is ignored; no queuing.
- diff and borrow hold their last result through IDLE until the next final bit is written. diff is not updated visibly during SHIFT: an output register is loaded from the shift path on the transition to DONE.
- Arithmetic: diff = (a − b) mod 2^WIDTH; borrow = (a < b) unsigned. Cell equations: d = x⊕y⊕bin, bout = (¬x∧y) ∨ (¬(x⊕y)∧bin).
- Counter width is $clog2(WIDTH) and wraps only via reload.
- rst during SHIFT aborts the operation: no done pulse; outputs take reset values.

## Timing
- Start accepted at edge k.
- SHIFT occupies the cycles after edges k..k+WIDTH−1.
- done is high in the cycle after edge k+WIDTH, so latency is WIDTH+1 cycles from start sample to done.
- busy is high for exactly WIDTH cycles per operation.
- Back-to-back: start held high gives one result every WIDTH+1 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- SERIAL_SUB_OVF_EN defined:
  - Port ovf exists.
  - ovf = (a[MSB] ≠ b[MSB]) ∧ (diff[MSB] ≠ a[MSB]), with a[MSB] and b[MSB] latched at load.
  - ovf is registered with diff at DONE, has the same hold rules as diff, and resets to 0.
- Undefined: ovf port, its sign latches and its logic are absent. All other behaviour is identical.

## Structure
- Package serial_sub_pkg: state typedef (IDLE, SHIFT, DONE), state encoding constants.
- Sub-module full_subtractor: combinational x, y, bin → d, bout, instantiated once.
- The top contains the FSM, shift registers, counter, borrow flop and output registers.

## Test plan
- WIDTH=8, a=0x05, b=0x03, start pulse → done exactly 9 cycles later, diff=0x02, borrow=0, busy high 8 cycles.
- a=0x03, b=0x05 → diff=0xFE, borrow=1. Then a=0x00, b=0x00 → diff=0x00, borrow=0.
- a=0x20, b=0x01 with start, then start re-pulsed with a=0xFF, b=0x00 on cycle 3 of SHIFT → ignored; done once, diff=0x1F.
- start held high with a=0xFF, b=0x01 → done pulses every 9 cycles, each diff=0xFE, no extra pulses.
- rst asserted on cycle 4 of SHIFT → next cycle busy=0, done=0, diff=0; no done pulse follows. A fresh start completes normally.
- SERIAL_SUB_OVF_EN:
  - a=0x80, b=0x01 → diff=0x7F, ovf=1.
  - a=0x7F, b=0x01 → diff=0x7E, ovf=0.
